dmem_responder: RTL and testbench

//  Data-memory responder: the slave end of the execute stage's memory request port (addr/mem_re/we/store_data).

---
 rtl/dmem_pkg.sv | 44 ++++
 rtl/dmem_bank.sv | 31 +++
 rtl/dmem_responder.sv | 160 ++++++++++++++++
 tb/tb_dmem_responder.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_pkg.sv
// Shared types for the data-memory responder: access sizes, opcode ranges,
// FSM states and the opcode decode helper.
package dmem_pkg;

    localparam logic [4:0] OP_W_LO = 5'd3;
    localparam logic [4:0] OP_W_HI = 5'd5;
    localparam logic [4:0] OP_D_LO = 5'd6;
    localparam logic [4:0] OP_D_HI = 5'd8;
    localparam logic [4:0] OP_B_LO = 5'd9;
    localparam logic [4:0] OP_B_HI = 5'd11;

    typedef enum logic [1:0] {
        SIZE_W = 2'd0,
        SIZE_D = 2'd1,
        SIZE_B = 2'd2
    } size_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_HOLD = 2'd3
    } state_e;

    // Opcodes outside the three ranges are treated as word accesses.
    function automatic size_e opcode_size(input logic [4:0] op);
        size_e s;
        s = SIZE_W;
        if (op >= OP_W_LO && op <= OP_W_HI) begin
            s = SIZE_W;
        end else if (op >= OP_D_LO && op <= OP_D_HI) begin
            s = SIZE_D;
        end else if (op >= OP_B_LO && op <= OP_B_HI) begin
            s = SIZE_B;
        end
        return s;
    endfunction

    // A beat is the first half of a split access when it crosses a word boundary.
    function automatic logic crosses_word(input size_e s, input logic [1:0] k);
        return ((s == SIZE_W) && (k != 2'd0)) || ((s == SIZE_D) && (k == 2'd3));
    endfunction

endpackage

// File: rtl/dmem_bank.sv
// Byte-lane synchronous RAM: per-lane write enables, registered read port
// that returns the word contents from before a same-edge write.
module dmem_bank #(
    parameter int DEPTH_WORDS = 4096,
    localparam int AW = $clog2(DEPTH_WORDS)
) (
    input  logic          clk,
    input  logic [AW-1:0] idx_i,
    input  logic          rd_en_i,
    input  logic [3:0]    wr_be_i,
    input  logic [31:0]   wr_data_i,
    output logic [31:0]   rd_data_o
);

    logic [3:0][7:0] mem_q [DEPTH_WORDS];
    logic [31:0]     rd_q;

    always_ff @(posedge clk) begin
        if (rd_en_i) begin
            rd_q <= mem_q[idx_i];
        end
        for (int i = 0; i < 4; i++) begin
            if (wr_be_i[i]) begin
                mem_q[idx_i][i] <= wr_data_i[8*i +: 8];
            end
        end
    end

    assign rd_data_o = rd_q;

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: accepts load/store beats, optionally stalls for a fixed
// number of cycles, and merges the two beats of a word-crossing load.
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int DEPTH_WORDS = 4096,
    parameter int WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        clk_en,
    input  logic [31:0] addr,
    input  logic        mem_re,
    input  logic [3:0]  we,
    input  logic [31:0] store_data,
    input  logic [4:0]  opcode,
    input  logic        second_beat,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        mem_stall,
    output logic        proto_err,
    output state_e      state_dbg
);

    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    // Handshake: a beat is taken on a clk_en edge when (mem_re || |we) and
    // mem_stall is low; while mem_stall is high the requester holds the beat.
    state_e      state_q;
    logic [3:0]  wait_cnt_q;
    size_e       cur_size_q;
    logic [1:0]  cur_k_q;
    logic        cur_first_q;
    logic        cur_merge_q;
    logic        cur_pulse_q;
    logic [31:0] hold_q;
    logic        load_valid_q;
    logic        proto_err_q;

    size_e       acc_size;
    logic [1:0]  acc_k;
    logic        acc_req;
    logic        accept;
    logic        pend_now;
    logic        acc_first;
    logic        acc_merge;
    logic        acc_pulse;
    logic        acc_orphan;
    logic [31:0] rd_data;
    logic [31:0] shifted;
    logic [31:0] result_d;
    logic        unused_addr_hi;

    assign unused_addr_hi = ^addr[31:AW+2];

    always_comb begin
        acc_size   = opcode_size(opcode);
        acc_k      = addr[1:0];
        acc_req    = mem_re | (|we);
        accept     = clk_en & acc_req & (state_q != ST_WAIT);
        // A first beat still in RESP is captured on the same edge a second beat may arrive.
        pend_now   = (state_q == ST_HOLD) | ((state_q == ST_RESP) & cur_first_q);
        acc_first  = !second_beat && crosses_word(acc_size, acc_k);
        acc_merge  = second_beat & pend_now;
        acc_orphan = second_beat & !pend_now;
        acc_pulse  = mem_re & !acc_first & !acc_orphan;
    end

    dmem_bank #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_bank (
        .clk       (clk),
        .idx_i     (addr[AW+1:2]),
        .rd_en_i   (accept & mem_re),
        .wr_be_i   (accept ? we : 4'h0),
        .wr_data_i (store_data),
        .rd_data_o (rd_data)
    );

    always_comb begin
        shifted  = rd_data >> {cur_k_q, 3'b000};
        result_d = shifted;
        if (cur_merge_q) begin
            if (cur_size_q == SIZE_D) begin
                result_d = {16'h0000, rd_data[7:0], hold_q[7:0]};
            end else begin
                result_d = hold_q | (rd_data << (6'd32 - {1'b0, cur_k_q, 3'b000}));
            end
        end else begin
            case (cur_size_q)
                SIZE_B:  result_d = {24'h000000, shifted[7:0]};
                SIZE_D:  result_d = {16'h0000, shifted[15:0]};
                default: result_d = shifted;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            wait_cnt_q   <= 4'd0;
            cur_size_q   <= SIZE_W;
            cur_k_q      <= 2'd0;
            cur_first_q  <= 1'b0;
            cur_merge_q  <= 1'b0;
            cur_pulse_q  <= 1'b0;
            hold_q       <= 32'h0;
            load_valid_q <= 1'b0;
            proto_err_q  <= 1'b0;
        end else if (clk_en) begin
            if (state_q == ST_RESP && cur_first_q) begin
                hold_q <= shifted;
            end
            if (accept) begin
                cur_size_q  <= acc_size;
                cur_k_q     <= acc_k;
                cur_first_q <= acc_first;
                cur_merge_q <= acc_merge;
                cur_pulse_q <= acc_pulse;
                if (acc_orphan) begin
                    proto_err_q <= 1'b1;
                end
                if (WAIT_STATES == 0) begin
                    state_q      <= ST_RESP;
                    load_valid_q <= acc_pulse;
                end else begin
                    state_q      <= ST_WAIT;
                    wait_cnt_q   <= WS;
                    load_valid_q <= 1'b0;
                end
            end else begin
                load_valid_q <= 1'b0;
                case (state_q)
                    ST_WAIT: begin
                        if (wait_cnt_q <= 4'd1) begin
                            state_q      <= ST_RESP;
                            wait_cnt_q   <= 4'd0;
                            load_valid_q <= cur_pulse_q;
                        end else begin
                            wait_cnt_q <= wait_cnt_q - 4'd1;
                        end
                    end
                    ST_RESP: state_q <= cur_first_q ? ST_HOLD : ST_IDLE;
                    ST_HOLD: state_q <= ST_HOLD;
                    default: state_q <= ST_IDLE;
                endcase
            end
        end
    end

    // RAM read data is only meaningful during RESP, so load_data is a decode of
    // registered state and is forced to zero outside the valid cycle.
    assign load_data  = load_valid_q ? result_d : 32'h0;
    assign load_valid = load_valid_q;
    assign mem_stall  = (state_q == ST_WAIT);
    assign proto_err  = proto_err_q;
    assign state_dbg  = state_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench: zero-wait instance driven from a vector table, plus a
// two-wait-state instance exercised by hand-written stall/reset sequences.
module tb_dmem_responder;
    import dmem_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        clk_en = 1'b1;
    logic [31:0] addr;
    logic        mem_re;
    logic [3:0]  we;
    logic [31:0] store_data;
    logic [4:0]  opcode;
    logic        second_beat;

    logic [31:0] load_data0, load_data2;
    logic        load_valid0, load_valid2;
    logic        mem_stall0, mem_stall2;
    logic        proto_err0, proto_err2;
    state_e      state0, state2;

    int pass_cnt = 0;
    int chk_cnt  = 0;
    logic [31:0] exp_q[$];

    typedef struct {
        logic [31:0] a;
        logic        re;
        logic [3:0]  w;
        logic [31:0] d;
        logic [4:0]  op;
        logic        sb;
        logic        exp_lv;
        logic [31:0] exp_data;
        logic        exp_perr;
    } vec_t;

    localparam int NV = 27;
    vec_t vecs[NV];

    dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .addr(addr), .mem_re(mem_re),
        .we(we), .store_data(store_data), .opcode(opcode), .second_beat(second_beat),
        .load_data(load_data0), .load_valid(load_valid0), .mem_stall(mem_stall0),
        .proto_err(proto_err0), .state_dbg(state0)
    );

    dmem_responder #(.DEPTH_WORDS(4096), .WAIT_STATES(2)) dut2 (
        .clk(clk), .rst(rst), .clk_en(clk_en), .addr(addr), .mem_re(mem_re),
        .we(we), .store_data(store_data), .opcode(opcode), .second_beat(second_beat),
        .load_data(load_data2), .load_valid(load_valid2), .mem_stall(mem_stall2),
        .proto_err(proto_err2), .state_dbg(state2)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] a, input logic re, input logic [3:0] w,
                         input logic [31:0] d, input logic [4:0] op, input logic sb);
        addr = a; mem_re = re; we = w; store_data = d; opcode = op; second_beat = sb;
    endtask

    task automatic idle();
        drive(32'h0, 1'b0, 4'h0, 32'h0, 5'd3, 1'b0);
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    function automatic vec_t mk(input logic [31:0] a, input logic re, input logic [3:0] w,
                                input logic [31:0] d, input logic [4:0] op, input logic sb,
                                input logic elv, input logic [31:0] ed, input logic ep);
        vec_t v;
        v.a = a; v.re = re; v.w = w; v.d = d; v.op = op; v.sb = sb;
        v.exp_lv = elv; v.exp_data = ed; v.exp_perr = ep;
        return v;
    endfunction

    initial begin
        int lat;
        int stalls;
        int pulses;
        logic got;

        vecs[0]  = mk(32'h10,   0, 4'hF, 32'hDEADBEEF, 3,  0, 0, 32'h0, 0);
        vecs[1]  = mk(32'h10,   1, 4'h0, 32'h0,        3,  0, 1, 32'hDEADBEEF, 0);
        vecs[2]  = mk(32'h13,   1, 4'h0, 32'h0,        9,  0, 1, 32'h000000DE, 0);
        vecs[3]  = mk(32'h12,   1, 4'h0, 32'h0,        6,  0, 1, 32'h0000DEAD, 0);
        vecs[4]  = mk(32'h14,   0, 4'hF, 32'h11223344, 3,  0, 0, 32'h0, 0);
        vecs[5]  = mk(32'h11,   1, 4'h0, 32'h0,        4,  0, 0, 32'h0, 0);
        vecs[6]  = mk(32'h15,   1, 4'h0, 32'h0,        4,  1, 1, 32'h44DEADBE, 0);
        vecs[7]  = mk(32'h13,   1, 4'h0, 32'h0,        7,  0, 0, 32'h0, 0);
        vecs[8]  = mk(32'h17,   1, 4'h0, 32'h0,        7,  1, 1, 32'h000044DE, 0);
        vecs[9]  = mk(32'h10,   1, 4'h0, 32'h0,        11, 0, 1, 32'h000000EF, 0);
        vecs[10] = mk(32'h15,   1, 4'h0, 32'h0,        10, 0, 1, 32'h00000033, 0);
        vecs[11] = mk(32'h10,   0, 4'h4, 32'h00AA0000, 3,  0, 0, 32'h0, 0);
        vecs[12] = mk(32'h10,   1, 4'h0, 32'h0,        3,  0, 1, 32'hDEAABEEF, 0);
        vecs[13] = mk(32'h10,   1, 4'hF, 32'h55667788, 3,  0, 1, 32'hDEAABEEF, 0);
        vecs[14] = mk(32'h10,   1, 4'h0, 32'h0,        3,  0, 1, 32'h55667788, 0);
        vecs[15] = mk(32'h10,   1, 4'h0, 32'h0,        8,  0, 1, 32'h00007788, 0);
        vecs[16] = mk(32'h12,   1, 4'h0, 32'h0,        3,  0, 0, 32'h0, 0);
        vecs[17] = mk(32'h16,   1, 4'h0, 32'h0,        3,  1, 1, 32'h33445566, 0);
        vecs[18] = mk(32'h13,   1, 4'h0, 32'h0,        3,  0, 0, 32'h0, 0);
        vecs[19] = mk(32'h17,   1, 4'h0, 32'h0,        3,  1, 1, 32'h22334455, 0);
        vecs[20] = mk(32'h3FFC, 0, 4'hF, 32'hCAFEF00D, 3,  0, 0, 32'h0, 0);
        vecs[21] = mk(32'h0,    0, 4'hF, 32'h01020304, 3,  0, 0, 32'h0, 0);
        vecs[22] = mk(32'h3FFE, 1, 4'h0, 32'h0,        5,  0, 0, 32'h0, 0);
        vecs[23] = mk(32'h4002, 1, 4'h0, 32'h0,        5,  1, 1, 32'h0304CAFE, 0);
        vecs[24] = mk(32'h11,   1, 4'h0, 32'h0,        3,  0, 0, 32'h0, 0);
        vecs[25] = mk(32'h14,   1, 4'h0, 32'h0,        3,  0, 1, 32'h11223344, 0);
        vecs[26] = mk(32'h15,   1, 4'h0, 32'h0,        3,  1, 0, 32'h0, 1);

        // Reset state of both instances.
        idle();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst lv0",    32'(load_valid0), 32'h0);
        check("rst ld0",    load_data0,       32'h0);
        check("rst stall0", 32'(mem_stall0),  32'h0);
        check("rst perr0",  32'(proto_err0),  32'h0);
        check("rst state0", 32'(state0),      32'(ST_IDLE));
        check("rst lv2",    32'(load_valid2), 32'h0);
        check("rst stall2", 32'(mem_stall2),  32'h0);
        check("rst state2", 32'(state2),      32'(ST_IDLE));
        rst = 1'b0;
        step();

        // Two wait states: write, then a read with stall/latency measurement.
        drive(32'h20, 1'b0, 4'hF, 32'hA5A55A5A, 5'd3, 1'b0);
        step();
        idle();
        check("ws2 stall after write", 32'(mem_stall2), 32'h1);
        for (int c = 0; c < 8 && mem_stall2; c++) step();
        check("ws2 write done", 32'(mem_stall2), 32'h0);

        drive(32'h20, 1'b1, 4'h0, 32'h0, 5'd3, 1'b0);
        exp_q.push_back(32'hA5A55A5A);
        lat = 0; stalls = 0; got = 1'b0;
        for (int c = 1; c <= 8 && !got; c++) begin
            step();
            if (c == 1) idle();
            if (mem_stall2) stalls++;
            if (load_valid2) begin
                got = 1'b1;
                lat = c;
                check("ws2 read data", load_data2, exp_q.pop_front());
            end
        end
        check("ws2 read seen",    32'(got),          32'h1);
        check("ws2 latency",      32'(lat),          32'd3);
        check("ws2 stall cycles", 32'(stalls),       32'd2);
        check("ws2 queue empty",  32'(exp_q.size()), 32'd0);
        step();
        check("ws2 lv one cycle", 32'(load_valid2), 32'h0);

        // Orphan second beat on the waited instance, then reset in the middle of a wait.
        drive(32'h24, 1'b1, 4'h0, 32'h0, 5'd3, 1'b1);
        step();
        idle();
        check("ws2 orphan perr", 32'(proto_err2), 32'h1);
        pulses = 0;
        for (int c = 0; c < 4; c++) begin
            step();
            if (load_valid2) pulses++;
        end
        check("ws2 orphan no lv", 32'(pulses), 32'd0);
        drive(32'h20, 1'b1, 4'h0, 32'h0, 5'd3, 1'b0);
        step();
        idle();
        check("ws2 midwait stall", 32'(mem_stall2), 32'h1);
        rst = 1'b1;
        #1;
        check("midrst lv2",    32'(load_valid2), 32'h0);
        check("midrst ld2",    load_data2,       32'h0);
        check("midrst stall2", 32'(mem_stall2),  32'h0);
        check("midrst perr2",  32'(proto_err2),  32'h0);
        check("midrst state2", 32'(state2),      32'(ST_IDLE));
        @(negedge clk);
        rst = 1'b0;
        step();

        // Zero-wait instance: table of single-cycle beats, one response check each.
        for (int i = 0; i < NV; i++) begin
            drive(vecs[i].a, vecs[i].re, vecs[i].w, vecs[i].d, vecs[i].op, vecs[i].sb);
            step();
            check($sformatf("row%0d lv", i),    32'(load_valid0), 32'(vecs[i].exp_lv));
            check($sformatf("row%0d data", i),  load_data0,       vecs[i].exp_data);
            check($sformatf("row%0d perr", i),  32'(proto_err0),  32'(vecs[i].exp_perr));
            check($sformatf("row%0d stall", i), 32'(mem_stall0),  32'h0);
        end
        idle();
        step();
        check("idle lv0", 32'(load_valid0), 32'h0);

        // clk_en low freezes outputs and ignores requests.
        drive(32'h14, 1'b1, 4'h0, 32'h0, 5'd3, 1'b0);
        step();
        check("pre-freeze lv", 32'(load_valid0), 32'h1);
        check("pre-freeze ld", load_data0,       32'h11223344);
        clk_en = 1'b0;
        drive(32'h10, 1'b1, 4'h0, 32'h0, 5'd3, 1'b0);
        step();
        step();
        check("freeze lv",   32'(load_valid0), 32'h1);
        check("freeze ld",   load_data0,       32'h11223344);
        check("freeze perr", 32'(proto_err0),  32'h1);
        clk_en = 1'b1;
        idle();
        step();
        check("thaw lv", 32'(load_valid0), 32'h0);
        check("thaw ld", load_data0,       32'h0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
